// File: rtl/debug_step_fsm.sv
// Single-step controller: each host step byte advances the datapath one clock,
// then requests a state dump; ends on host abort or after HALT has drained.
module debug_step_fsm #(
    parameter int                          UART_BITS        = 8,
    parameter int                          INSTRUCTION_BITS = 32,
    parameter int                          CLK_COUNTER_BITS = 32,
    parameter logic [INSTRUCTION_BITS-1:0] HALT_INSTRUCTION = {INSTRUCTION_BITS{1'b1}},
    parameter int                          DRAIN_STEPS      = 3,
    parameter logic [UART_BITS-1:0]        CMD_STEP         = UART_BITS'(8'h01),
    parameter logic [UART_BITS-1:0]        CMD_ABORT        = UART_BITS'(8'h02)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_start,
    input  logic                        i_rx_done,
    input  logic [UART_BITS-1:0]        i_rx_data,
    input  logic                        i_send_done,
    input  logic [INSTRUCTION_BITS-1:0] i_instruction,
    output logic                        o_enable,
    output logic                        o_send_start,
    output logic [CLK_COUNTER_BITS-1:0] o_clk_count,
    output logic                        o_done
);

    // Keep the drain counter at least one bit wide so DRAIN_STEPS=0 still elaborates.
    localparam int DRAIN_W = (DRAIN_STEPS > 0) ? $clog2(DRAIN_STEPS + 1) : 1;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_CMD,
        STEP,
        SEND,
        WAIT_SEND,
        FINISH
    } state_t;

    state_t                      state, state_nxt;
    logic [CLK_COUNTER_BITS-1:0] clk_count, clk_count_nxt;
    logic                        halted, halted_nxt;
    logic [DRAIN_W-1:0]          drain, drain_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            clk_count <= '0;
            halted    <= 1'b0;
            drain     <= '0;
        end else begin
            state     <= state_nxt;
            clk_count <= clk_count_nxt;
            halted    <= halted_nxt;
            drain     <= drain_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        clk_count_nxt = clk_count;
        halted_nxt    = halted;
        drain_nxt     = drain;
        o_enable      = 1'b0;
        o_send_start  = 1'b0;
        o_done        = 1'b0;

        case (state)
            IDLE: begin
                if (i_start) begin
                    state_nxt     = WAIT_CMD;
                    clk_count_nxt = '0;
                    halted_nxt    = 1'b0;
                    drain_nxt     = '0;
                end
            end
            WAIT_CMD: begin
                if (i_rx_done) begin
                    if (i_rx_data == CMD_STEP)       state_nxt = STEP;
                    else if (i_rx_data == CMD_ABORT) state_nxt = FINISH;
                end
            end
            STEP: begin
                o_enable      = 1'b1;
                clk_count_nxt = clk_count + 1'b1;
                state_nxt     = SEND;
            end
            SEND: begin
                // IF/ID has already taken the stepped instruction by this cycle.
                o_send_start = 1'b1;
                state_nxt    = WAIT_SEND;
                if (!halted && (i_instruction == HALT_INSTRUCTION)) begin
                    halted_nxt = 1'b1;
                    drain_nxt  = DRAIN_W'(DRAIN_STEPS);
                end else if (halted && (drain != '0)) begin
                    drain_nxt = drain - 1'b1;
                end
            end
            WAIT_SEND: begin
                // Host bytes arriving during the dump are intentionally dropped.
                if (i_send_done) begin
                    if (halted && (drain == '0)) state_nxt = FINISH;
                    else                         state_nxt = WAIT_CMD;
                end
            end
            FINISH: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign o_clk_count = clk_count;

endmodule

// File: tb/tb_debug_step_fsm.sv
// Bench for debug_step_fsm: vector table, directed multi-cycle sequences and
// randomized traffic checked against a timestamp-based session model.
module tb_debug_step_fsm;

    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam int          DRAIN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_start = 1'b0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_send_done = 1'b0;
    logic [31:0] i_instruction = NOP;
    logic        o_enable, o_send_start, o_done;
    logic [31:0] o_clk_count;

    int checks = 0;
    int errors = 0;

    debug_step_fsm dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_rx_done    (i_rx_done),
        .i_rx_data    (i_rx_data),
        .i_send_done  (i_send_done),
        .i_instruction(i_instruction),
        .o_enable     (o_enable),
        .o_send_start (o_send_start),
        .o_clk_count  (o_clk_count),
        .o_done       (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; i_start = 1'b0; i_rx_done = 1'b0; i_rx_data = 8'h00;
        i_send_done = 1'b0; i_instruction = NOP;
    endtask

    task automatic do_reset();
        @(negedge clk); clear_inputs(); rst = 1'b1;
        @(negedge clk); @(negedge clk); rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); i_start = 1'b1;
        @(negedge clk); i_start = 1'b0;
    endtask

    // One host step: send the step byte, acknowledge the dump, watch 3 more cycles.
    task automatic host_step(input logic [31:0] instr, output int n_en, output int n_done);
        bit sent;
        n_en = 0; n_done = 0; sent = 0;
        i_instruction = instr;
        @(negedge clk); i_rx_done = 1'b1; i_rx_data = 8'h01;
        @(negedge clk); i_rx_done = 1'b0;
        for (int t = 0; t < 20 && !sent; t++) begin
            if (o_enable) n_en++;
            if (o_done) n_done++;
            if (o_send_start) sent = 1;
            @(negedge clk);
        end
        chk("step_send_seen", sent, 1'b1);
        i_send_done = 1'b1;
        @(negedge clk); i_send_done = 1'b0;
        for (int t = 0; t < 3; t++) begin
            if (o_enable) n_en++;
            if (o_done) n_done++;
            @(negedge clk);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic        rst, start, rx_done;
        logic [7:0]  rx_data;
        logic        send_done;
        logic        en, send, done;
        logic [31:0] count;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic s, input logic rx, input logic [7:0] d,
                                input logic sd, input logic en, input logic snd, input logic dn,
                                input logic [31:0] c);
        vec_t v;
        v.rst = r; v.start = s; v.rx_done = rx; v.rx_data = d; v.send_done = sd;
        v.en = en; v.send = snd; v.done = dn; v.count = c;
        return v;
    endfunction

    // ---------------- reference model ----------------
    // Tracks a session as timestamps of scheduled pulses rather than as states.
    bit      m_active, m_ready, m_wait_dump, m_halt;
    int      m_rem;
    longint  m_en_at, m_send_at, m_done_at;
    logic [31:0] m_count;

    task automatic m_reset();
        m_active = 0; m_ready = 0; m_wait_dump = 0; m_halt = 0; m_rem = 0;
        m_en_at = -1; m_send_at = -1; m_done_at = -1; m_count = '0;
    endtask

    task automatic m_cycle(input longint t);
        if (rst) begin
            m_reset();
            return;
        end
        if (t == m_en_at) m_count = m_count + 32'd1;
        if (m_wait_dump && i_send_done) begin
            m_wait_dump = 0;
            if (m_halt && m_rem == 0) m_done_at = t + 1;
            else                      m_ready = 1;
        end else if (m_ready && i_rx_done) begin
            if (i_rx_data == 8'h01) begin
                m_ready = 0; m_en_at = t + 1; m_send_at = t + 2;
            end else if (i_rx_data == 8'h02) begin
                m_ready = 0; m_done_at = t + 1;
            end
        end
        if (t == m_send_at) begin
            if (!m_halt && i_instruction == HALT) begin
                m_halt = 1; m_rem = DRAIN;
            end else if (m_halt && m_rem > 0) begin
                m_rem--;
            end
            m_wait_dump = 1;
        end
        if (!m_active && i_start) begin
            m_active = 1; m_ready = 1; m_count = '0; m_halt = 0; m_rem = 0;
        end
        if (t == m_done_at) m_active = 0;
    endtask

    initial begin
        vec_t vecs[$];
        int   n_en, n_done, tot_en, tot_done;
        bit   seen;

        // Tests 1, 4, 5: outputs listed are those observed in the cycle the inputs are driven.
        vecs.push_back(mk(1,0,0,8'h00,0, 0,0,0,0));  // reset state
        vecs.push_back(mk(0,1,0,8'h00,0, 0,0,0,0));  // IDLE, start
        vecs.push_back(mk(0,0,1,8'h01,0, 0,0,0,0));  // WAIT_CMD, step byte
        vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,0));  // STEP
        vecs.push_back(mk(0,0,0,8'h00,0, 0,1,0,1));  // SEND
        vecs.push_back(mk(0,1,1,8'h01,0, 0,0,0,1));  // WAIT_SEND: byte and start dropped
        vecs.push_back(mk(0,0,0,8'h00,1, 0,0,0,1));  // WAIT_SEND: dump done
        vecs.push_back(mk(0,0,1,8'h07,0, 0,0,0,1));  // WAIT_CMD: junk byte
        vecs.push_back(mk(0,0,1,8'h01,0, 0,0,0,1));  // WAIT_CMD: step
        vecs.push_back(mk(0,0,0,8'h00,0, 1,0,0,1));  // STEP
        vecs.push_back(mk(0,0,0,8'h00,0, 0,1,0,2));  // SEND
        vecs.push_back(mk(0,0,1,8'h01,1, 0,0,0,2));  // WAIT_SEND: send_done wins, byte dropped
        vecs.push_back(mk(0,0,1,8'h02,0, 0,0,0,2));  // WAIT_CMD: abort
        vecs.push_back(mk(0,0,0,8'h00,0, 0,0,1,2));  // FINISH
        vecs.push_back(mk(0,0,0,8'h00,0, 0,0,0,2));  // IDLE, count held
        vecs.push_back(mk(0,0,1,8'h01,0, 0,0,0,2));  // IDLE ignores bytes
        vecs.push_back(mk(0,0,0,8'h00,0, 0,0,0,2));

        do_reset();
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; i_start = vecs[i].start; i_rx_done = vecs[i].rx_done;
            i_rx_data = vecs[i].rx_data; i_send_done = vecs[i].send_done; i_instruction = NOP;
            chk($sformatf("vec%0d_enable", i), o_enable, vecs[i].en);
            chk($sformatf("vec%0d_send", i), o_send_start, vecs[i].send);
            chk($sformatf("vec%0d_done", i), o_done, vecs[i].done);
            chk($sformatf("vec%0d_count", i), o_clk_count, vecs[i].count);
        end
        @(negedge clk); clear_inputs();

        // Test 2: five plain steps, then abort to close the session.
        do_reset();
        pulse_start();
        tot_en = 0; tot_done = 0;
        for (int s = 0; s < 5; s++) begin
            host_step(NOP, n_en, n_done);
            tot_en += n_en; tot_done += n_done;
        end
        chk("five_steps_enables", tot_en, 5);
        chk("five_steps_no_done", tot_done, 0);
        chk("five_steps_count", o_clk_count, 5);
        i_rx_done = 1'b1; i_rx_data = 8'h02;
        @(negedge clk); i_rx_done = 1'b0;
        chk("abort_done", o_done, 1'b1);
        chk("abort_no_enable", o_enable, 1'b0);

        // Test 3: HALT in IF/ID from step 2 on, three drain steps follow.
        pulse_start();
        tot_en = 0;
        for (int s = 1; s <= 5; s++) begin
            host_step((s >= 2) ? HALT : NOP, n_en, n_done);
            tot_en += n_en;
            chk($sformatf("halt_step%0d_done", s), n_done, (s == 5) ? 1 : 0);
        end
        chk("halt_enables", tot_en, 5);
        chk("halt_count", o_clk_count, 5);

        // Test 6: reset while waiting for the dump.
        pulse_start();
        i_rx_done = 1'b1; i_rx_data = 8'h01;
        @(negedge clk); i_rx_done = 1'b0;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            if (o_send_start) seen = 1;
            @(negedge clk);
        end
        chk("rst_reach_wait_send", seen, 1'b1);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("rst_enable", o_enable, 1'b0);
        chk("rst_send", o_send_start, 1'b0);
        chk("rst_done", o_done, 1'b0);
        chk("rst_count", o_clk_count, 0);
        i_send_done = 1'b1;
        @(negedge clk); i_send_done = 1'b0;
        chk("rst_still_idle_done", o_done, 1'b0);
        pulse_start();
        host_step(NOP, n_en, n_done);
        chk("post_rst_enable", n_en, 1);
        chk("post_rst_count", o_clk_count, 1);

        // Randomized traffic against the model.
        do_reset();
        m_reset();
        for (longint t = 0; t < 4000; t++) begin
            @(negedge clk);
            chk("rnd_enable", o_enable, (t == m_en_at));
            chk("rnd_send", o_send_start, (t == m_send_at));
            chk("rnd_done", o_done, (t == m_done_at));
            chk("rnd_count", o_clk_count, m_count);
            rst         = ($urandom_range(0, 299) == 0);
            i_start     = ($urandom_range(0, 7) == 0);
            i_rx_done   = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0, 1, 2: i_rx_data = 8'h01;
                3:       i_rx_data = 8'h02;
                4:       i_rx_data = 8'h07;
                default: i_rx_data = 8'($urandom);
            endcase
            i_send_done   = ($urandom_range(0, 3) == 0);
            i_instruction = ($urandom_range(0, 5) == 0) ? HALT : $urandom;
            m_cycle(t);
        end
        @(negedge clk); clear_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
